regfile_access_ctrl: RTL and testbench
======================================

# regfile_access_ctrl

Initiator-side controller for the team's 32 x 32-bit register array built from write-enabled, tri-state-read register cells. Accepts one read or write request at a time over a valid/ready handshake. Decodes the address into one-hot per-register write and read strobes, drives write data onto the array's shared input, and captures read data from the shared tri-state read bus. Sits between the datapath/bus master and the register array.

## Interface
- NREGS, 32, number of registers attached
- WIDTH, 32, data width
- ADDR_W, 5, address width; NREGS <= 2**ADDR_W
- clk  in  1  clock; all state changes on posedge
- clr  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  register index
- req_wdata  in  WIDTH  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts read data
- rsp_rdata  out  WIDTH  captured read data
- wen  out  NREGS  one-hot per-register write enable
- ren  out  NREGS  one-hot per-register tri-state output enable
- bus_wdata  out  WIDTH  data to every register's input
- bus_rdata  in  WIDTH  shared tri-state read bus

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE: req_ready=1; wen=0, ren=0. On req_valid&&req_ready, latch we/addr/wdata; go to WRITE if we, else READ.
- WRITE (1 cycle): wen[addr]=1, bus_wdata=latched data; the register loads on the closing edge. Next state IDLE. Writes produce no response.
- READ (1 cycle): ren[addr]=1; rsp_rdata <= bus_rdata on the closing edge. Next state RESP.
- RESP: rsp_valid=1, rsp_rdata stable; stay until rsp_ready=1, then IDLE. req_ready=0.
- Register 0 is hardwired zero. A write to address 0 still spends the WRITE cycle with wen all-zero. A read of address 0 spends the READ cycle with ren all-zero and captures 0, not the floating bus.
- Addresses >= NREGS behave exactly like address 0.
- Invariants: wen and ren each zero or one-hot; never both nonzero in the same cycle.
- bus_wdata holds the last latched write data; it is 0 after reset.
- clr in any state: IDLE immediately, wen=0, ren=0, rsp_valid=0, rsp_rdata=0, bus_wdata=0, latched request discarded.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, wen=0, ren=0, bus_wdata=0.
- Write: accept edge T, wen strobe during cycle T+1, register updated at edge T+2, req_ready high again in cycle T+2. Throughput is 1 write per 2 cycles.
- Read: accept edge T, ren during cycle T+1, capture at edge T+2, rsp_valid from cycle T+2 until the rsp_ready handshake. Minimum 3 cycles per read.
- Write then read of the same address returns the new value; no forwarding is needed because the write completes before the READ state.
- req_ready is a registered state decode only; it has no combinational path from req_valid.
- rsp_valid is asserted independently of rsp_ready. rsp_rdata does not change while rsp_valid=1.

## Structure
- Shared package regfile_pkg:
  - state enum (IDLE, WRITE, READ, RESP)
  - default NREGS, WIDTH, ADDR_W constants
  - zero-register index constant (0)
- Sub-module regfile_addr_decoder(addr, en, onehot):
  - produces a one-hot NREGS vector gated by en
  - output is zero for address 0 and for addresses >= NREGS
  - instantiated twice, once for wen and once for ren

## Test plan
- Reset: assert clr mid-READ with ren[7]=1 -> ren=0 and rsp_valid=0 in the same cycle; req_ready=1 after release.
- Write 0xDEADBEEF to r5, then read r5:
  - wen=0x00000020 for exactly one cycle
  - ren=0x00000020 for exactly one cycle
  - rsp_rdata=0xDEADBEEF
- Write 0xFFFFFFFF to r0, then read r0:
  - wen stays 0 throughout
  - ren stays 0 throughout
  - rsp_rdata=0x00000000 even with bus_rdata forced to 'z or 0x12345678
- Read r31 (holding 0xA5A5A5A5) with rsp_ready low for 4 cycles:
  - rsp_valid held for 4 cycles
  - rsp_rdata stable at 0xA5A5A5A5
  - req_ready=0 until the rsp handshake
- Back-to-back writes r1..r31 with req_valid held high:
  - one accept every 2 cycles
  - wen walks 0x2 to 0x80000000
  - no cycle has wen and ren both nonzero
- NREGS=16, ADDR_W=5, read address 20 -> ren=0, rsp_rdata=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-array access controller.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int NREGS_DEF  = 32;
    localparam int WIDTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/regfile_addr_decoder.sv
// One-hot register strobe decoder; register 0 and out-of-range addresses never strobe.
module regfile_addr_decoder
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [NREGS-1:0]  onehot
);

    // Out-of-range addresses simply match no generated compare.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
        if (gi == ZERO_REG) begin : g_zero
            assign onehot[gi] = 1'b0;
        end else begin : g_reg
            assign onehot[gi] = en && (addr == ADDR_W'(gi));
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Single-outstanding read/write controller for a tri-state-read register array.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic [NREGS-1:0]  wen,
    output logic [NREGS-1:0]  ren,
    output logic [WIDTH-1:0]  bus_wdata,
    input  logic [WIDTH-1:0]  bus_rdata
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [WIDTH-1:0]  wdata_reg;
    logic [WIDTH-1:0]  rdata_reg;
    logic              accept;

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg <= req_addr;
            end
            // Only writes update the array's input bus, so it always shows the last write data.
            if (accept && req_we) begin
                wdata_reg <= req_wdata;
            end
            // No enabled register means the bus floats; return zero instead.
            if (state_reg == READ) begin
                rdata_reg <= (|ren) ? bus_rdata : '0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = req_we ? WRITE : READ;
            WRITE:   state_next = IDLE;
            READ:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign bus_wdata = wdata_reg;

    regfile_addr_decoder #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_wen_dec (
        .addr   (addr_reg),
        .en     (state_reg == WRITE),
        .onehot (wen)
    );

    regfile_addr_decoder #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_ren_dec (
        .addr   (addr_reg),
        .en     (state_reg == READ),
        .onehot (ren)
    );

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench with a behavioural register array and a read-data scoreboard.
module tb_regfile_access_ctrl;

    localparam int NR = 32;
    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_rdata;
    logic [NR-1:0] wen, ren;
    logic [W-1:0]  bus_wdata, bus_rdata;

    logic          v16, ready16, we16, rsp_valid16, rsp_ready16;
    logic [AW-1:0] addr16;
    logic [W-1:0]  wdata16, rdata16, bus_wdata16, bus_rdata16;
    logic [15:0]   wen16, ren16;

    logic          force_en;
    logic [W-1:0]  force_val;
    logic [W-1:0]  mem [NR];
    logic [W-1:0]  exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.NREGS(NR), .WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .wen(wen), .ren(ren), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    regfile_access_ctrl #(.NREGS(16), .WIDTH(W), .ADDR_W(AW)) dut16 (
        .clk(clk), .clr(clr),
        .req_valid(v16), .req_ready(ready16), .req_we(we16),
        .req_addr(addr16), .req_wdata(wdata16),
        .rsp_valid(rsp_valid16), .rsp_ready(rsp_ready16), .rsp_rdata(rdata16),
        .wen(wen16), .ren(ren16), .bus_wdata(bus_wdata16), .bus_rdata(bus_rdata16)
    );

    // Behavioural register array: write-enabled cells, tri-state shared read bus.
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (wen[i]) mem[i] <= bus_wdata;
        end
    end

    always_comb begin
        bus_rdata = force_en ? force_val : 'z;
        for (int i = 0; i < NR; i++) begin
            if (ren[i]) bus_rdata = mem[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
            $error("%s observed %h required %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("wen_ren_excl", 32'((wen != '0) && (ren != '0)), 32'd0);
        check("wen_onehot0", 32'($onehot0(wen)), 32'd1);
        check("ren_onehot0", 32'($onehot0(ren)), 32'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NR-1:0] exp_wen);
        check("wr_ready_pre", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0;
        check("wr_wen", wen, exp_wen);
        check("wr_bus_wdata", bus_wdata, d);
        check("wr_ready_busy", 32'(req_ready), 32'd0);
        step();
        check("wr_wen_off", wen, 32'd0);
        check("wr_ready_post", 32'(req_ready), 32'd1);
        $display("write r%0d data=%h", a, d);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [NR-1:0] exp_ren,
                           input logic [W-1:0] exp_data, input int stall);
        check("rd_ready_pre", 32'(req_ready), 32'd1);
        exp_q.push_back(exp_data);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        check("rd_ren", ren, exp_ren);
        check("rd_wen", wen, 32'd0);
        step();
        check("rd_ren_off", ren, 32'd0);
        for (int k = 0; k < stall; k++) begin
            check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
            check("rsp_ready_blocked", 32'(req_ready), 32'd0);
            check("rsp_rdata_stable", rsp_rdata, exp_data);
            step();
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) check("rsp_rdata", rsp_rdata, exp_q.pop_front());
        step();
        rsp_ready = 1'b0;
        check("rsp_valid_off", 32'(rsp_valid), 32'd0);
        check("rd_ready_post", 32'(req_ready), 32'd1);
        $display("read r%0d data=%h stall=%0d", a, rsp_rdata, stall);
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        v16 = 1'b0; we16 = 1'b0; addr16 = '0; wdata16 = '0; rsp_ready16 = 1'b0;
        bus_rdata16 = 32'h12345678;
        force_en = 1'b0; force_val = '0;

        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_wen", wen, 32'd0);
        check("rst_ren", ren, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        clr = 1'b0;
        step();

        do_write(5'd5, 32'hDEADBEEF, 32'h0000_0020);
        do_read(5'd5, 32'h0000_0020, 32'hDEADBEEF, 0);

        do_write(5'd0, 32'hFFFFFFFF, 32'd0);
        do_read(5'd0, 32'd0, 32'd0, 0);
        force_en = 1'b1; force_val = 32'h12345678;
        do_read(5'd0, 32'd0, 32'd0, 1);
        force_en = 1'b0;

        // Back-to-back writes with req_valid held: one accept every second cycle.
        for (int i = 1; i < NR; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(i);
            req_wdata = (i == 31) ? 32'hA5A5A5A5 : 32'h11110000 + 32'(i);
            step();
            check("b2b_wen", wen, 32'd1 << i);
            check("b2b_ready_low", 32'(req_ready), 32'd0);
            step();
            check("b2b_wen_off", wen, 32'd0);
            check("b2b_ready_high", 32'(req_ready), 32'd1);
            $display("b2b write r%0d wen=%h", i, 32'd1 << i);
        end
        req_valid = 1'b0;
        step();

        do_read(5'd31, 32'h8000_0000, 32'hA5A5A5A5, 4);
        do_read(5'd7, 32'h0000_0080, 32'h11110007, 0);

        // Asynchronous clear in the middle of a READ cycle.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7;
        step();
        req_valid = 1'b0;
        check("clr_pre_ren", ren, 32'h0000_0080);
        #2 clr = 1'b1;
        #1;
        check("clr_ren", ren, 32'd0);
        check("clr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("clr_rsp_rdata", rsp_rdata, 32'd0);
        check("clr_bus_wdata", bus_wdata, 32'd0);
        check("clr_req_ready", 32'(req_ready), 32'd1);
        step();
        clr = 1'b0;
        step();
        check("clr_rel_ready", 32'(req_ready), 32'd1);
        check("clr_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        $display("clear during read r7");

        // 16-register instance: address 20 is out of range and reads as zero.
        v16 = 1'b1; we16 = 1'b0; addr16 = 5'd20;
        step();
        v16 = 1'b0;
        check("n16_ren", 32'(ren16), 32'd0);
        step();
        check("n16_rsp_valid", 32'(rsp_valid16), 32'd1);
        check("n16_rsp_rdata", rdata16, 32'd0);
        rsp_ready16 = 1'b1;
        step();
        rsp_ready16 = 1'b0;
        check("n16_ready", 32'(ready16), 32'd1);
        $display("n16 read r20 data=%h", rdata16);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
